arb8_rr: RTL and testbench

Round-robin arbiter that shares one 32-bit, 8:1 selection datapath among eight requesters and drives a single valid/ready output channel. It registers the 3-bit select of the mux8, so one granted requester's word appears on `out_data`. Each accepted beat is returned to its requester as a one-cycle `in_ack` pulse. The block sits between eight producer units and a shared downstream consumer.

---
 rtl/arb8_rr_if.sv | 24 ++
 rtl/arb8_rr.sv | 110 +++++++++++
 tb/tb_arb8_rr.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb8_rr_if.sv
// arb8_rr_if: request/data/ack bundle from eight producers plus the shared
// valid/ready output channel of the round-robin arbiter.
interface arb8_rr_if;
  logic [7:0]   in_req;
  logic [255:0] in_data;
  logic [7:0]   in_lock;
  logic [7:0]   in_ack;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_sel;

  // arbiter side
  modport slave (
    input  in_req, in_data, in_lock, out_ready,
    output in_ack, out_valid, out_data, out_sel
  );

  // producer/consumer side
  modport master (
    output in_req, in_data, in_lock, out_ready,
    input  in_ack, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb8_rr.sv
// arb8_rr: 8-way round-robin arbiter steering one 32-bit word through a
// registered-select mux8 onto a valid/ready channel, acking each accepted beat.
// Optional feature macro: ARB8_LOCK_EN (grant held across beats while the
// grantee's in_lock bit is set). Default build ignores in_lock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; out_valid low; arbitrate on any request
// BUSY  | out_sel holds the grantee; out_valid high until accept/withdraw
module arb8_rr (
  input  logic      clock,
  input  logic      reset,
  arb8_rr_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] req_masked;
  logic [7:0] ack;
  logic       accept;
  logic       lock_hold;

  // First asserted request scanning base, base+1, ... base+7 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] win;
    win = base;
    for (int k = 7; k >= 0; k--) begin
      idx = base + k[2:0];
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

`ifdef ARB8_LOCK_EN
  assign lock_hold = bus.in_lock[sel_q];
`else
  logic lock_unused;
  assign lock_unused = ^bus.in_lock;
  assign lock_hold   = 1'b0;
`endif

  // State, pointer and select registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, re-arbitration on accept, and ack generation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    ack        = '0;
    accept     = 1'b0;
    req_masked = bus.in_req;
    case (state_q)
      IDLE: begin
        if (|bus.in_req) begin
          sel_d   = rr_pick(bus.in_req, ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        accept = bus.out_ready && !reset;
        if (accept) begin
          ack = 8'd1 << sel_q;
          // A locked grantee keeps the channel; pointer and select stay put.
          if (!lock_hold) begin
            ptr_d             = sel_q + 3'd1;
            req_masked[sel_q] = 1'b0;
            if (|req_masked) begin
              sel_d = rr_pick(req_masked, ptr_d);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (!bus.in_req[sel_q]) begin
          // Withdrawn before acceptance: drop the grant, no ack, ptr kept.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ack    = ack;
  assign bus.out_valid = (state_q == BUSY) && !reset;
  assign bus.out_sel   = sel_q;
  assign bus.out_data  = bus.in_data[{sel_q, 5'b0} +: 32];

`ifndef SYNTHESIS
  // Ack is one-hot and only ever accompanies a valid beat.
  a_ack_onehot: assert property (@(posedge clock) $onehot0(bus.in_ack));
  a_ack_valid:  assert property (@(posedge clock)
                                 (|bus.in_ack) |-> bus.out_valid);
`endif

endmodule

// File: tb/tb_arb8_rr.sv
// tb_arb8_rr: directed stimulus for arb8_rr with a scoreboard of expected
// beats (select + data) drained by an independent output monitor.
module tb_arb8_rr;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  arb8_rr_if bus();

  arb8_rr dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] data);
    beat_t b;
    b.sel  = 3'(idx);
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    bus.in_data[idx*32 +: 32] = v;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard;
  // any other cycle must carry no ack.
  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sel %0d expected no beat",
                 bus.out_sel);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_sel", 32'(bus.out_sel), 32'(mon_e.sel));
        check("beat_data", bus.out_data, mon_e.data);
        check("beat_ack", 32'(bus.in_ack), 32'(8'd1 << mon_e.sel));
      end
    end else begin
      check("no_accept_ack", 32'(bus.in_ack), 32'd0);
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.in_req = 8'hFF;
    bus.in_lock = 8'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) bus.in_data[i*32 +: 32] = 32'hA000_0000 + i;

    // Reset with all requests pending.
    tick();
    @(negedge clock);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ack", 32'(bus.in_ack), 32'd0);
    tick();
    reset = 1'b0;

    // Full rotation 0..7,0 with ready held high.
    for (int i = 0; i < 8; i++) push(i, 32'hA000_0000 + i);
    push(0, 32'hA000_0000);
    tick();
    @(negedge clock);
    check("first_grant_valid", 32'(bus.out_valid), 32'd1);
    check("first_grant_sel", 32'(bus.out_sel), 32'd0);
    repeat (9) tick();
    bus.out_ready = 1'b0;

    // Stall: grantee 1 held, nothing acked.
    repeat (5) begin
      @(negedge clock);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sel", 32'(bus.out_sel), 32'd1);
      check("stall_data", bus.out_data, 32'hA000_0001);
      tick();
    end

    // Withdraw grantee 1; ptr must stay 1 so {1,2} grants 1 first.
    bus.in_req = 8'hFD;
    tick();
    bus.in_req = 8'h06;
    bus.out_ready = 1'b1;
    push(1, 32'hA000_0001);
    push(2, 32'hA000_0002);
    @(negedge clock);
    check("withdraw_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_req = 8'h04;
    tick();
    bus.in_req = 8'h00;
    tick();
    @(negedge clock);
    check("drain_idle_valid", 32'(bus.out_valid), 32'd0);

    // Move ptr to 7, then {2,7} must grant 7 then wrap to 2.
    bus.in_req = 8'h40;
    push(6, 32'hA000_0006);
    tick();
    bus.in_req = 8'h00;
    tick();
    bus.in_req = 8'h84;
    push(7, 32'hA000_0007);
    push(2, 32'hA000_0002);
    tick();
    bus.in_req = 8'h04;
    tick();
    bus.in_req = 8'h00;
    tick();

    // Lone continuous requester 3: grant, accept, one IDLE cycle, grant.
    bus.in_req = 8'h08;
    push(3, 32'hA000_0003);
    push(3, 32'hA000_0003);
    tick();
    tick();
    @(negedge clock);
    check("mask_gap_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_req = 8'h00;
    tick();

    // Requester 4 with lock 1,1,0 while 5 waits.
    set_word(4, 32'hB000_0000);
    bus.in_req = 8'h30;
    bus.in_lock = 8'h10;
`ifdef ARB8_LOCK_EN
    push(4, 32'hB000_0000);
    push(4, 32'hB000_0001);
    push(4, 32'hB000_0002);
    push(5, 32'hA000_0005);
    tick();
    tick();
    set_word(4, 32'hB000_0001);
    tick();
    set_word(4, 32'hB000_0002);
    bus.in_lock = 8'h00;
    tick();
    bus.in_req = 8'h20;
    tick();
`else
    push(4, 32'hB000_0000);
    push(5, 32'hA000_0005);
    tick();
    tick();
    bus.in_req = 8'h20;
    tick();
`endif
    bus.in_req = 8'h00;
    bus.in_lock = 8'h00;
    set_word(4, 32'hA000_0004);

    // Reset mid-transfer: grantee 1 stalled, then reset with ready high.
    bus.in_req = 8'h02;
    bus.out_ready = 1'b0;
    tick();
    @(negedge clock);
    check("pre_rst_sel", 32'(bus.out_sel), 32'd1);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ack", 32'(bus.in_ack), 32'd0);
    tick();
    reset = 1'b0;
    bus.in_req = 8'h82;
    push(1, 32'hA000_0001);
    push(7, 32'hA000_0007);
    @(negedge clock);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_sel", 32'(bus.out_sel), 32'd0);
    check("post_rst_data", bus.out_data, 32'hA000_0000);
    tick();
    bus.in_req = 8'h80;
    tick();
    bus.in_req = 8'h00;
    tick();

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
